apb_master: RTL
===============

// Module: apb_master
// PURPOSE
// - APB initiator: turns a simple valid/ready command into one APB3 transfer
//   (SETUP then ACCESS phase) on a single-slave bus.
// - Returns read data and error status to the requester.
// - Drives the same bus a DEPTH-parameterised APB memory slave responds on.
// - Bounds slave wait states with a timeout counter.
// PARAMETERS
// - TIMEOUT   default 16   max ACCESS cycles with _PREADY low before abort (>=2)
// - CNT_W     default 8    width of the completed-transfer counter
// PORTS
// - _PCLK        in   1      bus clock, all logic on rising edge
// - _PRESETn     in   1      asynchronous, active-low reset
// - cmd_valid    in   1      requester has a command
// - cmd_ready    out  1      master can accept a command (IDLE only)
// - cmd_write    in   1      1 = write, 0 = read
// - cmd_addr     in   32     transfer address
// - cmd_wdata    in   32     write data (ignored for reads)
// - rsp_valid    out  1      one-cycle pulse: transfer finished
// - rsp_rdata    out  32     read data (0 for writes, errors and timeouts)
// - rsp_err      out  1      _PSLVERR seen, or timeout, on this transfer
// - rsp_timeout  out  1      transfer aborted by timeout
// - xfer_cnt     out  CNT_W  completed transfers (incl. errors), wraps
// - _PSEL1       out  1      slave select
// - _PENABLE     out  1      ACCESS phase strobe
// - _PWRITE      out  1      transfer direction
// - _PADDR       out  32     address
// - _PWDATA      out  32     write data
// - _PRDATA      in   32     slave read data
// - _PREADY      in   1      slave ready
// - _PSLVERR     in   1      slave error, valid while _PREADY=1
// BEHAVIOUR
// - Reset (async, while _PRESETn=0): state IDLE; every output 0 except
//   cmd_ready, which is 1 once out of reset. Applies mid-transfer: the bus
//   drops immediately and any pending response is lost (no rsp_valid).
// - All outputs are registered; no combinational path from input to output.
// - FSM states: IDLE, SETUP, ACCESS, RESP.
// - IDLE: cmd_ready=1. cmd_valid & cmd_ready at edge N latches
//   write/addr/wdata into _PWRITE/_PADDR/_PWDATA and moves to SETUP.
// - SETUP (cycle N+1): _PSEL1=1, _PENABLE=0; always moves to ACCESS.
// - ACCESS (cycle N+2 onward): _PSEL1=1, _PENABLE=1. _PADDR, _PWRITE,
//   _PWDATA stay stable for the whole transfer.
//   - Edge where _PREADY=1: capture rsp_rdata (=_PRDATA if read and
//     !_PSLVERR, else 0) and rsp_err=_PSLVERR; go to RESP.
//   - Wait counter starts at 0 on SETUP->ACCESS and increments each ACCESS
//     edge with _PREADY=0. When it reaches TIMEOUT: go to RESP with
//     rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//   - _PREADY=1 on the same edge the counter would hit TIMEOUT: normal
//     completion wins.
// - RESP (one cycle): rsp_valid=1; _PSEL1=0, _PENABLE=0; xfer_cnt+1
//   (wraps 2^CNT_W-1 -> 0); next state IDLE.
// - rsp_rdata/rsp_err/rsp_timeout hold until the next RESP overwrites them.
// - Latency: zero-wait transfer = accept edge N, rsp_valid in cycle N+3.
//   Back-to-back commands are 4 cycles apart (IDLE visited once).
// - No response backpressure: requester must take rsp_valid when it pulses.
// - cmd_valid while not in IDLE is ignored; cmd_ready=0 there.
// TESTING
// - Write 0x0000_0003 <- 0xDEAD_BEEF, zero-wait slave -> SETUP at N+1,
//   ACCESS at N+2, rsp_valid at N+3 with rsp_err=0; xfer_cnt 0->1.
// - Read 0x3 after that write, slave inserts 3 wait states -> _PENABLE high
//   4 cycles, address stable, rsp_rdata=0xDEAD_BEEF.
// - Read 0x40 from a DEPTH=5 slave -> _PSLVERR=1; rsp_err=1,
//   rsp_timeout=0, rsp_rdata=0.
// - Slave holds _PREADY=0 forever, TIMEOUT=16 -> abort after 16 ACCESS
//   cycles; rsp_err=1, rsp_timeout=1; bus idle next cycle.
// - _PRESETn low during ACCESS -> _PSEL1/_PENABLE 0 immediately, no
//   rsp_valid, cmd_ready=1 after release; next command completes normally.
// - 256 back-to-back writes with CNT_W=8 -> xfer_cnt wraps to 0;
//   accepts exactly 4 cycles apart.

Source files
------------

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//   APB3 initiator for a single-slave bus. Each accepted command becomes one
//   transfer (SETUP then ACCESS) and produces a one-cycle response carrying
//   read data and error/timeout status. The ACCESS phase is bounded: after
//   TIMEOUT cycles with _PREADY low the transfer is abandoned.
//
// Parameters
//   TIMEOUT  maximum ACCESS cycles with _PREADY low before abort (>= 2)
//   CNT_W    width of the completed-transfer counter
//
// Ports
//   _PCLK, _PRESETn                  clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready            command handshake
//   cmd_write, cmd_addr, cmd_wdata   command payload
//   rsp_valid                        one-cycle pulse when a transfer finishes
//   rsp_rdata, rsp_err, rsp_timeout  response payload, held until next response
//   xfer_cnt                         completed transfers, wraps
//   _PSEL1, _PENABLE, _PWRITE,
//   _PADDR, _PWDATA                  APB request signals
//   _PRDATA, _PREADY, _PSLVERR       APB completion signals
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only in IDLE; cmd_valid elsewhere is
// ignored. rsp_valid has no backpressure and must be taken when it pulses.
//
// Every output is either a flop or a pure decode of the state flops, so there
// is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module apb_master #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             _PCLK,
    input  logic             _PRESETn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             rsp_timeout,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             _PSEL1,
    output logic             _PENABLE,
    output logic             _PWRITE,
    output logic [31:0]      _PADDR,
    output logic [31:0]      _PWDATA,
    input  logic [31:0]      _PRDATA,
    input  logic             _PREADY,
    input  logic             _PSLVERR
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // state is the observable FSM state for checkers bound to this module.
    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_hit;

    // The counter holds the number of ACCESS edges already seen with _PREADY
    // low; the edge that would make it reach TIMEOUT is the abort edge.
    assign wait_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge _PCLK or negedge _PRESETn) begin
        if (!_PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        _PSEL1    = 1'b0;
        _PENABLE  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                _PSEL1    = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                _PSEL1   = 1'b1;
                _PENABLE = 1'b1;
                // A ready slave on the abort edge still completes normally.
                if (_PREADY || wait_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, wait counter, response capture, counter
    // ------------------------------------------------------------------
    always_ff @(posedge _PCLK or negedge _PRESETn) begin
        if (!_PRESETn) begin
            _PWRITE     <= 1'b0;
            _PADDR      <= 32'd0;
            _PWDATA     <= 32'd0;
            wait_cnt    <= '0;
            rsp_rdata   <= 32'd0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            xfer_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        _PWRITE <= cmd_write;
                        _PADDR  <= cmd_addr;
                        _PWDATA <= cmd_wdata;
                    end
                end
                SETUP: begin
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    if (_PREADY) begin
                        // Read data is only meaningful for a clean read.
                        rsp_rdata   <= (!_PWRITE && !_PSLVERR) ? _PRDATA : 32'd0;
                        rsp_err     <= _PSLVERR;
                        rsp_timeout <= 1'b0;
                        xfer_cnt    <= xfer_cnt + CNT_W'(1);
                    end else if (wait_hit) begin
                        rsp_rdata   <= 32'd0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        xfer_cnt    <= xfer_cnt + CNT_W'(1);
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
